turn_controller: RTL and testbench
==================================

# turn_controller

Parametrised game-flow controller for the board-game datapath, successor to the fixed two-player, 8x8 control FSM. It sequences board initialisation, cursor movement, piece selection with an ownership check, destination selection, the move-validator handshake, the move commit, and the win or turn-timeout decision. It also arbitrates board-memory access among control, validator, datapath and view. It sits between the input debouncers and the datapath/validator/view blocks.

## Interface
- BOARD_W, 8: board columns (x); XW = max(1, clog2(BOARD_W))
- BOARD_H, 8: board rows (y); YW = max(1, clog2(BOARD_H))
- NUM_PLAYERS, 2: players, 2..8; PLW = max(1, clog2(NUM_PLAYERS))
- PIECE_W, 4: piece code width; code 0 = empty
- KING_MASK, 16'h1040: bit c set means capturing code c wins (width 2^PIECE_W)
- MOVE_DIV, 12500000: cycles per cursor step while a direction is held (>=1)
- WRAP, 0: 1 = cursor wraps at edges, 0 = cursor clamps
- TURN_TIMEOUT, 0: cycles allowed per turn; 0 disables the timeout
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; returns to S_INIT
- up, down, left, right  in  1  cursor direction levels; up/down act on x, right/left act on y
- select, deselect  in  1  levels; only rising edges are acted on
- new_game  in  1  leaves S_GAME_OVER
- piece_read  in  PIECE_W  piece at the current memory address, same cycle
- piece_owner  in  PLW  owner of piece_read
- initialize_complete, validate_complete, move_valid  in  1  datapath and validator feedback
- current_player  out  PLW  player to move
- winner  out  PLW; winning_msg  out  1
- piece_x, move_x, box_x  out  XW; piece_y, move_y, box_y  out  YW
- piece_to_move  out  PIECE_W
- memory_manage  out  2  memory owner: 00 control, 01 validator, 10 datapath, 11 view
- start_validation, move_piece, initialize_board, can_render, turn_timeout, select_reject  out  1

## Operation
- States: S_INIT, S_SEL_PIECE, S_SEL_DEST, S_VALIDATE, S_COMMIT, S_GAME_OVER.
- S_INIT
  - Outputs: initialize_board=1, memory_manage=10.
  - Clears current_player, winner, winning_msg, all coordinates and the turn counter.
  - On initialize_complete, go to S_SEL_PIECE.
- S_SEL_PIECE
  - Cursor enabled.
  - On a select rise, if piece_read!=0 and piece_owner==current_player: latch piece_x/y=box, piece_to_move=piece_read, go to S_SEL_DEST.
  - Otherwise pulse select_reject for 1 cycle and stay.
- S_SEL_DEST
  - Cursor enabled.
  - A deselect rise returns to S_SEL_PIECE. Deselect wins over a simultaneous select rise.
  - On a select rise: latch move_x/y=box and dest_king=KING_MASK[piece_read], go to S_VALIDATE.
- S_VALIDATE
  - memory_manage=01; start_validation is a 1-cycle pulse on entry.
  - Wait for validate_complete. Then move_valid=1 goes to S_COMMIT, move_valid=0 goes to S_SEL_DEST.
- S_COMMIT
  - One cycle: move_piece=1, memory_manage=10.
  - If dest_king: winner=current_player, winning_msg=1, go to S_GAME_OVER.
  - Otherwise advance the player and go to S_SEL_PIECE.
- S_GAME_OVER: memory_manage=11; new_game goes to S_INIT.
- Player advance: NUM_PLAYERS-1 wraps to 0. Advancing clears the turn counter.
- Timeout (TURN_TIMEOUT>0)
  - The counter increments only in S_SEL_PIECE and S_SEL_DEST.
  - At count TURN_TIMEOUT-1: pulse turn_timeout, advance the player, go to S_SEL_PIECE.
  - A timeout takes priority over a same-cycle select rise.
- Cursor
  - The divider counts while the cursor is enabled and a direction is held. A step is taken at count MOVE_DIV-1.
  - Opposite directions held together cancel on that axis.
  - At an edge the cursor clamps (WRAP=0) or wraps to the other edge (WRAP=1). With WRAP=1 the wrap is modulo BOARD_W/BOARD_H, not 2^XW.
- memory_manage is 00 in both select states. can_render=0 in S_INIT and S_COMMIT, 1 in all other states.

## Timing
- Reset state: S_INIT. All registers are 0. Combinational outputs follow S_INIT: initialize_board=1, memory_manage=10, can_render=0.
- Reset asserted mid-operation aborts immediately, including during S_VALIDATE and S_COMMIT.
- Select/deselect edge detect: one register stage. A rise is acted on in the cycle after the input goes high.
- A select rise to the S_SEL_DEST transition takes 1 cycle. S_COMMIT lasts exactly 1 cycle.
- A held select produces no repeated action.
- validate_complete is sampled only in S_VALIDATE.

## Structure
- Package game_pkg: state encoding; memory_manage codes MM_CONTROL/MM_VALIDATOR/MM_DATAPATH/MM_VIEW.
- Sub-module cursor_ctrl holds the box position, the divider and the clamp/wrap logic. Its parameters are BOARD_W, BOARD_H, MOVE_DIV and WRAP.

## Test plan
- Ownership check (MOVE_DIV=1): current_player=0, piece_read=5, piece_owner=1, select rise -> select_reject pulse, state stays S_SEL_PIECE. Same with owner=0 -> S_SEL_DEST, piece_to_move=5.
- Invalid move: validate_complete with move_valid=0 -> S_SEL_DEST, player unchanged. Valid move -> move_piece for 1 cycle, current_player 0->1.
- Win and restart (NUM_PLAYERS=3): player 2 captures code 6 -> winning_msg=1, winner=2, memory_manage=11. new_game -> S_INIT.
- Cursor edges (BOARD_W=5, WRAP=0): hold up 10 steps -> box_x=4. With WRAP=1, one step from 4 -> 0. Up+down held together -> box_x unchanged.
- Timeout (TURN_TIMEOUT=20): idle in S_SEL_DEST -> turn_timeout at cycle 20, player advances, state S_SEL_PIECE.
- Reset asserted during S_VALIDATE -> immediate S_INIT, all coordinates 0, initialize_board=1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the board-game control slice.
// Contents: FSM state encoding, board-memory owner codes and a width helper.
package game_pkg;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_SEL_PIECE = 3'd1,
        S_SEL_DEST  = 3'd2,
        S_VALIDATE  = 3'd3,
        S_COMMIT    = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    // Board-memory owner codes driven on memory_manage
    localparam logic [1:0] MM_CONTROL   = 2'b00;
    localparam logic [1:0] MM_VALIDATOR = 2'b01;
    localparam logic [1:0] MM_DATAPATH  = 2'b10;
    localparam logic [1:0] MM_VIEW      = 2'b11;

    // Index width for n items, never below one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// Board cursor: holds the highlighted box position and steps it while a
// direction is held, one step every MOVE_DIV enabled cycles.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clear              forces the cursor (and divider) back to (0,0)
//   enable             cursor may move (piece/destination selection)
//   up, down           +x / -x direction levels
//   right, left        +y / -y direction levels
//   box_x, box_y       current cursor position
module cursor_ctrl
    import game_pkg::*;
#(
    parameter int BOARD_W  = 8,
    parameter int BOARD_H  = 8,
    parameter int MOVE_DIV = 12500000,
    parameter int WRAP     = 0,
    localparam int XW = clog2_min1(BOARD_W),
    localparam int YW = clog2_min1(BOARD_H),
    localparam int DW = clog2_min1(MOVE_DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    output logic [XW-1:0] box_x,
    output logic [YW-1:0] box_y
);

    logic [DW-1:0] div_r;
    logic          held_s;
    logic          step_s;
    logic [XW-1:0] x_next_s;
    logic [YW-1:0] y_next_s;

    // Step strobe and next position; opposite directions cancel per axis,
    // edges clamp or wrap modulo the board size (not the field width)
    always_comb begin
        held_s   = up | down | left | right;
        step_s   = enable && held_s && (div_r == DW'(MOVE_DIV - 1));
        x_next_s = box_x;
        y_next_s = box_y;
        if (up && !down) begin
            if (box_x == XW'(BOARD_W - 1)) begin
                x_next_s = (WRAP != 0) ? {XW{1'b0}} : box_x;
            end else begin
                x_next_s = box_x + XW'(1);
            end
        end else if (down && !up) begin
            if (box_x == {XW{1'b0}}) begin
                x_next_s = (WRAP != 0) ? XW'(BOARD_W - 1) : box_x;
            end else begin
                x_next_s = box_x - XW'(1);
            end
        end else begin
            x_next_s = box_x;
        end
        if (right && !left) begin
            if (box_y == YW'(BOARD_H - 1)) begin
                y_next_s = (WRAP != 0) ? {YW{1'b0}} : box_y;
            end else begin
                y_next_s = box_y + YW'(1);
            end
        end else if (left && !right) begin
            if (box_y == {YW{1'b0}}) begin
                y_next_s = (WRAP != 0) ? YW'(BOARD_H - 1) : box_y;
            end else begin
                y_next_s = box_y - YW'(1);
            end
        end else begin
            y_next_s = box_y;
        end
    end

    // Divider and position registers; divider restarts whenever motion stops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= {DW{1'b0}};
            box_x <= {XW{1'b0}};
            box_y <= {YW{1'b0}};
        end else if (clear) begin
            div_r <= {DW{1'b0}};
            box_x <= {XW{1'b0}};
            box_y <= {YW{1'b0}};
        end else begin
            if (enable && held_s) begin
                div_r <= step_s ? {DW{1'b0}} : div_r + DW'(1);
            end else begin
                div_r <= {DW{1'b0}};
            end
            if (step_s) begin
                box_x <= x_next_s;
                box_y <= y_next_s;
            end
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Game-flow controller: board init, piece/destination selection with
// ownership check, validator handshake, move commit, win and turn timeout,
// plus board-memory arbitration.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   up/down/left/right            cursor direction levels
//   select, deselect              levels, acted on at their rising edge
//   new_game                      leave the game-over state
//   piece_read, piece_owner       piece and owner at the current address
//   initialize_complete           datapath finished clearing the board
//   validate_complete, move_valid validator result
//   current_player, winner, winning_msg
//   piece_x/y, move_x/y, box_x/y  source, destination and cursor squares
//   piece_to_move                 latched source piece code
//   memory_manage                 board-memory owner (game_pkg MM_* codes)
//   start_validation, move_piece, initialize_board, can_render,
//   turn_timeout, select_reject   control strobes and levels
module turn_controller
    import game_pkg::*;
#(
    parameter int BOARD_W      = 8,
    parameter int BOARD_H      = 8,
    parameter int NUM_PLAYERS  = 2,
    parameter int PIECE_W      = 4,
    parameter logic [(2**PIECE_W)-1:0] KING_MASK = 16'h1040,
    parameter int MOVE_DIV     = 12500000,
    parameter int WRAP         = 0,
    parameter int TURN_TIMEOUT = 0,
    localparam int XW  = clog2_min1(BOARD_W),
    localparam int YW  = clog2_min1(BOARD_H),
    localparam int PLW = clog2_min1(NUM_PLAYERS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               select,
    input  logic               deselect,
    input  logic               new_game,
    input  logic [PIECE_W-1:0] piece_read,
    input  logic [PLW-1:0]     piece_owner,
    input  logic               initialize_complete,
    input  logic               validate_complete,
    input  logic               move_valid,
    output logic [PLW-1:0]     current_player,
    output logic [PLW-1:0]     winner,
    output logic               winning_msg,
    output logic [XW-1:0]      piece_x,
    output logic [YW-1:0]      piece_y,
    output logic [XW-1:0]      move_x,
    output logic [YW-1:0]      move_y,
    output logic [XW-1:0]      box_x,
    output logic [YW-1:0]      box_y,
    output logic [PIECE_W-1:0] piece_to_move,
    output logic [1:0]         memory_manage,
    output logic               start_validation,
    output logic               move_piece,
    output logic               initialize_board,
    output logic               can_render,
    output logic               turn_timeout,
    output logic               select_reject
);

    localparam int TW = clog2_min1(TURN_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

    state_t        state_r;
    logic          sel_d_r;
    logic          desel_d_r;
    logic          dest_king_r;
    logic [TW-1:0] turn_cnt_r;

    logic           sel_rise_s;
    logic           desel_rise_s;
    logic           timeout_s;
    logic [PLW-1:0] pl_next_s;
    logic           cursor_en_s;
    logic           cursor_clr_s;

    // Edge detect, timeout strobe, next player and decoded outputs
    always_comb begin
        sel_rise_s   = select & ~sel_d_r;
        desel_rise_s = deselect & ~desel_d_r;
        timeout_s    = (TURN_TIMEOUT > 0) && (turn_cnt_r == TO_LAST);
        if (current_player == PLW'(NUM_PLAYERS - 1)) begin
            pl_next_s = {PLW{1'b0}};
        end else begin
            pl_next_s = current_player + PLW'(1);
        end
        cursor_en_s      = 1'b0;
        cursor_clr_s     = 1'b0;
        memory_manage    = MM_CONTROL;
        initialize_board = 1'b0;
        move_piece       = 1'b0;
        can_render       = 1'b1;
        case (state_r)
            S_INIT: begin
                cursor_clr_s     = 1'b1;
                memory_manage    = MM_DATAPATH;
                initialize_board = 1'b1;
                can_render       = 1'b0;
            end
            S_SEL_PIECE, S_SEL_DEST: begin
                cursor_en_s   = 1'b1;
                memory_manage = MM_CONTROL;
            end
            S_VALIDATE: begin
                memory_manage = MM_VALIDATOR;
            end
            S_COMMIT: begin
                memory_manage = MM_DATAPATH;
                move_piece    = 1'b1;
                can_render    = 1'b0;
            end
            S_GAME_OVER: begin
                memory_manage = MM_VIEW;
            end
            default: begin
                memory_manage    = MM_DATAPATH;
                initialize_board = 1'b1;
                can_render       = 1'b0;
            end
        endcase
    end

    // Game-flow FSM with registered strobes and latched move data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= S_INIT;
            sel_d_r          <= 1'b0;
            desel_d_r        <= 1'b0;
            dest_king_r      <= 1'b0;
            turn_cnt_r       <= {TW{1'b0}};
            current_player   <= {PLW{1'b0}};
            winner           <= {PLW{1'b0}};
            winning_msg      <= 1'b0;
            piece_x          <= {XW{1'b0}};
            piece_y          <= {YW{1'b0}};
            move_x           <= {XW{1'b0}};
            move_y           <= {YW{1'b0}};
            piece_to_move    <= {PIECE_W{1'b0}};
            start_validation <= 1'b0;
            turn_timeout     <= 1'b0;
            select_reject    <= 1'b0;
        end else begin
            sel_d_r          <= select;
            desel_d_r        <= deselect;
            start_validation <= 1'b0;
            turn_timeout     <= 1'b0;
            select_reject    <= 1'b0;
            case (state_r)
                S_INIT: begin
                    dest_king_r    <= 1'b0;
                    turn_cnt_r     <= {TW{1'b0}};
                    current_player <= {PLW{1'b0}};
                    winner         <= {PLW{1'b0}};
                    winning_msg    <= 1'b0;
                    piece_x        <= {XW{1'b0}};
                    piece_y        <= {YW{1'b0}};
                    move_x         <= {XW{1'b0}};
                    move_y         <= {YW{1'b0}};
                    piece_to_move  <= {PIECE_W{1'b0}};
                    if (initialize_complete) begin
                        state_r <= S_SEL_PIECE;
                    end
                end
                S_SEL_PIECE: begin
                    // Timeout beats a same-cycle select
                    if (timeout_s) begin
                        turn_timeout   <= 1'b1;
                        current_player <= pl_next_s;
                        turn_cnt_r     <= {TW{1'b0}};
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TW'(1);
                        if (sel_rise_s) begin
                            if ((piece_read != {PIECE_W{1'b0}}) && (piece_owner == current_player)) begin
                                piece_x       <= box_x;
                                piece_y       <= box_y;
                                piece_to_move <= piece_read;
                                state_r       <= S_SEL_DEST;
                            end else begin
                                select_reject <= 1'b1;
                            end
                        end
                    end
                end
                S_SEL_DEST: begin
                    if (timeout_s) begin
                        turn_timeout   <= 1'b1;
                        current_player <= pl_next_s;
                        turn_cnt_r     <= {TW{1'b0}};
                        state_r        <= S_SEL_PIECE;
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TW'(1);
                        if (desel_rise_s) begin
                            state_r <= S_SEL_PIECE;
                        end else if (sel_rise_s) begin
                            move_x           <= box_x;
                            move_y           <= box_y;
                            dest_king_r      <= KING_MASK[piece_read];
                            start_validation <= 1'b1;
                            state_r          <= S_VALIDATE;
                        end
                    end
                end
                S_VALIDATE: begin
                    if (validate_complete) begin
                        state_r <= move_valid ? S_COMMIT : S_SEL_DEST;
                    end
                end
                S_COMMIT: begin
                    if (dest_king_r) begin
                        winner      <= current_player;
                        winning_msg <= 1'b1;
                        state_r     <= S_GAME_OVER;
                    end else begin
                        current_player <= pl_next_s;
                        turn_cnt_r     <= {TW{1'b0}};
                        state_r        <= S_SEL_PIECE;
                    end
                end
                S_GAME_OVER: begin
                    if (new_game) begin
                        state_r <= S_INIT;
                    end
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

    cursor_ctrl #(
        .BOARD_W  (BOARD_W),
        .BOARD_H  (BOARD_H),
        .MOVE_DIV (MOVE_DIV),
        .WRAP     (WRAP)
    ) u_cursor (
        .clk    (clk),
        .reset  (reset),
        .clear  (cursor_clr_s),
        .enable (cursor_en_s),
        .up     (up),
        .down   (down),
        .left   (left),
        .right  (right),
        .box_x  (box_x),
        .box_y  (box_y)
    );

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller. Two instances share the inputs:
// dut_a (3 players, 5x8 board, clamp, no timeout) and
// dut_b (same board, wrap, 20-cycle turn timeout).
module tb_turn_controller;
    import game_pkg::*;

    logic clk, reset, up, down, left, right, select, deselect, new_game;
    logic initialize_complete, validate_complete, move_valid;
    logic [3:0] piece_read;
    logic [1:0] piece_owner;

    logic [1:0] a_current_player, a_winner, a_memory_manage;
    logic [2:0] a_piece_x, a_piece_y, a_move_x, a_move_y, a_box_x, a_box_y;
    logic [3:0] a_piece_to_move;
    logic a_winning_msg, a_start_validation, a_move_piece, a_initialize_board;
    logic a_can_render, a_turn_timeout, a_select_reject;

    logic [1:0] b_current_player, b_winner, b_memory_manage;
    logic [2:0] b_piece_x, b_piece_y, b_move_x, b_move_y, b_box_x, b_box_y;
    logic [3:0] b_piece_to_move;
    logic b_winning_msg, b_start_validation, b_move_piece, b_initialize_board;
    logic b_can_render, b_turn_timeout, b_select_reject;

    int n_cmp  = 0;
    int n_fail = 0;

    turn_controller #(.BOARD_W(5), .BOARD_H(8), .NUM_PLAYERS(3), .PIECE_W(4),
                      .KING_MASK(16'h1040), .MOVE_DIV(1), .WRAP(0), .TURN_TIMEOUT(0)) dut_a (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
        .select(select), .deselect(deselect), .new_game(new_game),
        .piece_read(piece_read), .piece_owner(piece_owner),
        .initialize_complete(initialize_complete), .validate_complete(validate_complete),
        .move_valid(move_valid), .current_player(a_current_player), .winner(a_winner),
        .winning_msg(a_winning_msg), .piece_x(a_piece_x), .piece_y(a_piece_y),
        .move_x(a_move_x), .move_y(a_move_y), .box_x(a_box_x), .box_y(a_box_y),
        .piece_to_move(a_piece_to_move), .memory_manage(a_memory_manage),
        .start_validation(a_start_validation), .move_piece(a_move_piece),
        .initialize_board(a_initialize_board), .can_render(a_can_render),
        .turn_timeout(a_turn_timeout), .select_reject(a_select_reject)
    );

    turn_controller #(.BOARD_W(5), .BOARD_H(8), .NUM_PLAYERS(3), .PIECE_W(4),
                      .KING_MASK(16'h1040), .MOVE_DIV(1), .WRAP(1), .TURN_TIMEOUT(20)) dut_b (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
        .select(select), .deselect(deselect), .new_game(new_game),
        .piece_read(piece_read), .piece_owner(piece_owner),
        .initialize_complete(initialize_complete), .validate_complete(validate_complete),
        .move_valid(move_valid), .current_player(b_current_player), .winner(b_winner),
        .winning_msg(b_winning_msg), .piece_x(b_piece_x), .piece_y(b_piece_y),
        .move_x(b_move_x), .move_y(b_move_y), .box_x(b_box_x), .box_y(b_box_y),
        .piece_to_move(b_piece_to_move), .memory_manage(b_memory_manage),
        .start_validation(b_start_validation), .move_piece(b_move_piece),
        .initialize_board(b_initialize_board), .can_render(b_can_render),
        .turn_timeout(b_turn_timeout), .select_reject(b_select_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1 ns later
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset, then release and start a game (leaves both DUTs in S_SEL_PIECE)
    task automatic restart();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        initialize_complete = 1'b1;
        tick(1);
        initialize_complete = 1'b0;
    endtask

    // One complete turn from S_SEL_PIECE through commit (no checks here)
    task automatic drive_turn(input logic [3:0] src, input logic [1:0] own,
                              input logic [3:0] dst, input logic valid);
        piece_read = src; piece_owner = own; select = 1'b1; tick(1);
        select = 1'b0; tick(1);
        piece_read = dst; select = 1'b1; tick(1);
        select = 1'b0; tick(1);
        validate_complete = 1'b1; move_valid = valid; tick(1);
        validate_complete = 1'b0; move_valid = 1'b0; tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_cmp++; if (dut_a.state_r !== S_INIT) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut_a.state_r, S_INIT); end
        n_cmp++; if (a_initialize_board !== 1'b1) begin n_fail++; $display("FAIL reset_init_board: got %b want 1", a_initialize_board); end
        n_cmp++; if (a_memory_manage !== 2'b10) begin n_fail++; $display("FAIL reset_mm: got %b want 10", a_memory_manage); end
        n_cmp++; if (a_can_render !== 1'b0) begin n_fail++; $display("FAIL reset_render: got %b want 0", a_can_render); end
        n_cmp++; if ({a_current_player, a_box_x, a_piece_to_move} !== 9'd0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {a_current_player, a_box_x, a_piece_to_move}); end
        reset = 1'b0;
        tick(1);
        n_cmp++; if (dut_a.state_r !== S_INIT) begin n_fail++; $display("FAIL init_wait: got %0d want %0d", dut_a.state_r, S_INIT); end
        initialize_complete = 1'b1;
        tick(1);
        initialize_complete = 1'b0;
        n_cmp++; if (dut_a.state_r !== S_SEL_PIECE) begin n_fail++; $display("FAIL init_done: got %0d want %0d", dut_a.state_r, S_SEL_PIECE); end
        n_cmp++; if ({a_memory_manage, a_can_render, a_initialize_board} !== 4'b0010) begin n_fail++; $display("FAIL sel_outputs: got %b want 0010", {a_memory_manage, a_can_render, a_initialize_board}); end
    endtask

    task automatic test_ownership();
        piece_read = 4'd5; piece_owner = 2'd1; select = 1'b1;
        tick(1);
        n_cmp++; if (a_select_reject !== 1'b1) begin n_fail++; $display("FAIL reject_pulse: got %b want 1", a_select_reject); end
        n_cmp++; if (dut_a.state_r !== S_SEL_PIECE) begin n_fail++; $display("FAIL reject_state: got %0d want %0d", dut_a.state_r, S_SEL_PIECE); end
        tick(1);
        n_cmp++; if (a_select_reject !== 1'b0) begin n_fail++; $display("FAIL reject_held: got %b want 0", a_select_reject); end
        select = 1'b0; tick(1);
        piece_owner = 2'd0; select = 1'b1;
        tick(1);
        n_cmp++; if (dut_a.state_r !== S_SEL_DEST) begin n_fail++; $display("FAIL own_state: got %0d want %0d", dut_a.state_r, S_SEL_DEST); end
        n_cmp++; if (a_piece_to_move !== 4'd5) begin n_fail++; $display("FAIL own_piece: got %0d want 5", a_piece_to_move); end
        n_cmp++; if (a_select_reject !== 1'b0) begin n_fail++; $display("FAIL own_no_reject: got %b want 0", a_select_reject); end
        select = 1'b0; tick(1);
    endtask

    task automatic test_validate();
        piece_read = 4'd0; select = 1'b1;
        tick(1);
        n_cmp++; if (dut_a.state_r !== S_VALIDATE) begin n_fail++; $display("FAIL val_enter: got %0d want %0d", dut_a.state_r, S_VALIDATE); end
        n_cmp++; if ({a_start_validation, a_memory_manage} !== 3'b101) begin n_fail++; $display("FAIL val_start: got %b want 101", {a_start_validation, a_memory_manage}); end
        select = 1'b0; tick(1);
        n_cmp++; if ({a_start_validation, dut_a.state_r == S_VALIDATE} !== 2'b01) begin n_fail++; $display("FAIL val_pulse: got %b want 01", {a_start_validation, dut_a.state_r == S_VALIDATE}); end
        validate_complete = 1'b1; move_valid = 1'b0;
        tick(1);
        validate_complete = 1'b0;
        n_cmp++; if (dut_a.state_r !== S_SEL_DEST) begin n_fail++; $display("FAIL invalid_state: got %0d want %0d", dut_a.state_r, S_SEL_DEST); end
        n_cmp++; if (a_current_player !== 2'd0) begin n_fail++; $display("FAIL invalid_player: got %0d want 0", a_current_player); end
        select = 1'b1; tick(1);
        select = 1'b0;
        validate_complete = 1'b1; move_valid = 1'b1;
        tick(1);
        validate_complete = 1'b0; move_valid = 1'b0;
        n_cmp++; if ({a_move_piece, a_memory_manage, a_can_render} !== 4'b1100) begin n_fail++; $display("FAIL commit_out: got %b want 1100", {a_move_piece, a_memory_manage, a_can_render}); end
        tick(1);
        n_cmp++; if (a_move_piece !== 1'b0) begin n_fail++; $display("FAIL commit_len: got %b want 0", a_move_piece); end
        n_cmp++; if (a_current_player !== 2'd1) begin n_fail++; $display("FAIL commit_player: got %0d want 1", a_current_player); end
        n_cmp++; if (dut_a.state_r !== S_SEL_PIECE) begin n_fail++; $display("FAIL commit_next: got %0d want %0d", dut_a.state_r, S_SEL_PIECE); end
    endtask

    task automatic test_deselect();
        piece_read = 4'd3; piece_owner = 2'd1; select = 1'b1; tick(1);
        select = 1'b0; tick(1);
        select = 1'b1; deselect = 1'b1;
        tick(1);
        n_cmp++; if ({dut_a.state_r == S_SEL_PIECE, a_start_validation} !== 2'b10) begin n_fail++; $display("FAIL deselect_wins: got %b want 10", {dut_a.state_r == S_SEL_PIECE, a_start_validation}); end
        select = 1'b0; deselect = 1'b0; tick(1);
    endtask

    task automatic test_win();
        drive_turn(4'd3, 2'd1, 4'd0, 1'b1);
        n_cmp++; if (a_current_player !== 2'd2) begin n_fail++; $display("FAIL win_pre_player: got %0d want 2", a_current_player); end
        drive_turn(4'd3, 2'd2, 4'd6, 1'b1);
        n_cmp++; if ({a_winning_msg, a_winner, a_memory_manage, a_can_render} !== 6'b110111) begin n_fail++; $display("FAIL win_out: got %b want 110111", {a_winning_msg, a_winner, a_memory_manage, a_can_render}); end
        n_cmp++; if (dut_a.state_r !== S_GAME_OVER) begin n_fail++; $display("FAIL win_state: got %0d want %0d", dut_a.state_r, S_GAME_OVER); end
        new_game = 1'b1; tick(1);
        new_game = 1'b0;
        n_cmp++; if ({dut_a.state_r == S_INIT, a_initialize_board} !== 2'b11) begin n_fail++; $display("FAIL new_game: got %b want 11", {dut_a.state_r == S_INIT, a_initialize_board}); end
        tick(1);
        n_cmp++; if ({a_winning_msg, a_winner, a_current_player} !== 5'd0) begin n_fail++; $display("FAIL init_clear: got %b want 00000", {a_winning_msg, a_winner, a_current_player}); end
    endtask

    task automatic test_cursor_clamp();
        initialize_complete = 1'b1; tick(1);
        initialize_complete = 1'b0;
        up = 1'b1; tick(10);
        n_cmp++; if (a_box_x !== 3'd4) begin n_fail++; $display("FAIL clamp_up: got %0d want 4", a_box_x); end
        down = 1'b1; tick(3);
        n_cmp++; if (a_box_x !== 3'd4) begin n_fail++; $display("FAIL cancel_x: got %0d want 4", a_box_x); end
        up = 1'b0; tick(2);
        n_cmp++; if (a_box_x !== 3'd2) begin n_fail++; $display("FAIL step_down: got %0d want 2", a_box_x); end
        down = 1'b0; right = 1'b1; tick(10);
        right = 1'b0;
        n_cmp++; if (a_box_y !== 3'd7) begin n_fail++; $display("FAIL clamp_right: got %0d want 7", a_box_y); end
    endtask

    task automatic test_wrap();
        restart();
        up = 1'b1; tick(4);
        n_cmp++; if (b_box_x !== 3'd4) begin n_fail++; $display("FAIL wrap_pre: got %0d want 4", b_box_x); end
        tick(1);
        n_cmp++; if (b_box_x !== 3'd0) begin n_fail++; $display("FAIL wrap_up: got %0d want 0", b_box_x); end
        up = 1'b0; down = 1'b1; tick(1);
        down = 1'b0;
        n_cmp++; if (b_box_x !== 3'd4) begin n_fail++; $display("FAIL wrap_down: got %0d want 4", b_box_x); end
        left = 1'b1; tick(1);
        left = 1'b0;
        n_cmp++; if (b_box_y !== 3'd7) begin n_fail++; $display("FAIL wrap_left: got %0d want 7", b_box_y); end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        restart();
        piece_read = 4'd3; piece_owner = 2'd0; select = 1'b1; tick(1);
        select = 1'b0;
        n_cmp++; if (dut_b.state_r !== S_SEL_DEST) begin n_fail++; $display("FAIL to_dest: got %0d want %0d", dut_b.state_r, S_SEL_DEST); end
        k = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (b_turn_timeout === 1'b1) begin
                seen = 1'b1;
                k = i + 1;
            end
        end
        n_cmp++; if (!seen || k != 19) begin n_fail++; $display("FAIL to_cycle: got seen=%0d after %0d idle cycles want after 19", seen, k); end
        n_cmp++; if ({b_current_player, dut_b.state_r == S_SEL_PIECE} !== 3'b011) begin n_fail++; $display("FAIL to_advance: got %b want 011", {b_current_player, dut_b.state_r == S_SEL_PIECE}); end
        tick(1);
        n_cmp++; if (b_turn_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b want 0", b_turn_timeout); end
    endtask

    task automatic test_reset_validate();
        restart();
        up = 1'b1; tick(2);
        up = 1'b0;
        piece_read = 4'd3; piece_owner = 2'd0; select = 1'b1; tick(1);
        select = 1'b0;
        right = 1'b1; tick(1);
        right = 1'b0;
        piece_read = 4'd0; select = 1'b1; tick(1);
        select = 1'b0;
        n_cmp++; if ({dut_a.state_r == S_VALIDATE, a_piece_x, a_move_x, a_move_y} !== 10'b1_010_010_001) begin n_fail++; $display("FAIL rv_pre: got %b want 1010010001", {dut_a.state_r == S_VALIDATE, a_piece_x, a_move_x, a_move_y}); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (dut_a.state_r !== S_INIT) begin n_fail++; $display("FAIL rv_state: got %0d want %0d", dut_a.state_r, S_INIT); end
        n_cmp++; if ({a_box_x, a_box_y, a_piece_x, a_move_x, a_move_y} !== 15'd0) begin n_fail++; $display("FAIL rv_coords: got %h want 0", {a_box_x, a_box_y, a_piece_x, a_move_x, a_move_y}); end
        n_cmp++; if ({a_initialize_board, a_memory_manage} !== 3'b110) begin n_fail++; $display("FAIL rv_outputs: got %b want 110", {a_initialize_board, a_memory_manage}); end
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        select = 1'b0; deselect = 1'b0; new_game = 1'b0;
        initialize_complete = 1'b0; validate_complete = 1'b0; move_valid = 1'b0;
        piece_read = 4'd0; piece_owner = 2'd0;
        test_reset();
        test_ownership();
        test_validate();
        test_deselect();
        test_win();
        test_cursor_clamp();
        test_wrap();
        test_timeout();
        test_reset_validate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
